// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO controller: issues pops, absorbs the FIFO's 1-cycle read latency and
// presents words in pop order on a valid/ready port backed by a 2-entry skid buffer.
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  words_sent,
  output logic                  idle
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic [1:0]            count_reg, count_next;
  logic                  inflight_reg;
  logic [DATA_WIDTH-1:0] head_reg, head_next;
  logic [DATA_WIDTH-1:0] tail_reg, tail_next;
  logic [CNT_WIDTH-1:0]  sent_reg;
  logic                  hs;
  logic [2:0]            occupancy;

  assign out_valid  = (count_reg != 2'd0);
  assign out_data   = head_reg;
  assign words_sent = sent_reg;
  assign idle       = (state_reg == IDLE);
  assign hs         = out_valid & out_ready;

  // Words held after this edge, counting the one still in the FIFO's read pipeline.
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, hs};
  assign fifo_rd   = (state_reg == RUN) & ~fifo_empty & (occupancy < 3'd2);

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    case ({inflight_reg, hs})
      2'b10: begin
        if (count_reg == 2'd0) head_next = fifo_data;
        else                   tail_next = fifo_data;
        count_next = count_reg + 2'd1;
      end
      2'b01: begin
        head_next  = tail_reg;
        count_next = count_reg - 2'd1;
      end
      2'b11: begin
        // Simultaneous push and pop: the count is unchanged, the queue shifts.
        if (count_reg == 2'd2) begin
          head_next = tail_reg;
          tail_next = fifo_data;
        end else begin
          head_next = fifo_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (enable) state_next = RUN;
      RUN:   if (!enable) state_next = DRAIN;
      DRAIN: begin
        if (enable)                                    state_next = RUN;
        else if ((count_reg == 2'd0) && !inflight_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_reg    <= IDLE;
      count_reg    <= 2'd0;
      inflight_reg <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
      sent_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      inflight_reg <= fifo_rd;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      if (hs) sent_reg <= sent_reg + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl: a 1-cycle-latency FIFO model feeds the DUT and a
// monitor records every output handshake for order checks against hand-computed words.
module tb_fifo_drain_ctrl;
  localparam int DW = 6;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] words_sent;
  logic          idle;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fmem [0:63];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   pops = 0;
  logic empty_force = 1'b0;
  int   rx [$];

  fifo_drain_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .fifo_data(fifo_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .words_sent(words_sent), .idle(idle)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr) | empty_force;

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= fmem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
      pops      <= pops + 1;
    end
    if (reset_L && out_valid && out_ready) rx.push_back(int'(out_data));
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr[5:0]] = DW'(first + i);
      wr_ptr++;
    end
  endtask

  task automatic check_seq(input string tag, input int base, input int first, input int n);
    chk({tag, "_count"}, rx.size() - base, n);
    for (int i = 0; i < n; i++)
      chk(tag, (base + i < rx.size()) ? rx[base + i] : -1, first + i);
  endtask

  int exp_rd [7] = '{1, 1, 1, 1, 0, 0, 0};
  int exp_v  [7] = '{0, 0, 1, 1, 1, 1, 0};
  int exp_d  [7] = '{0, 0, 1, 2, 3, 4, 0};
  int base;
  int pops0;

  initial begin
    // Reset state
    tick(2);
    #1;
    chk("rst_idle", idle, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_rd", fifo_rd, 0);
    chk("rst_sent", words_sent, 0);
    chk("rst_data", out_data, 0);
    reset_L = 1'b1;

    // 1: four words streamed with the consumer always ready
    tick(1);
    load(1, 4);
    base = rx.size();
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      #1;
      chk($sformatf("t1_rd%0d", i), fifo_rd, exp_rd[i]);
      chk($sformatf("t1_valid%0d", i), out_valid, exp_v[i]);
      if (exp_v[i] != 0) chk($sformatf("t1_data%0d", i), out_data, exp_d[i]);
    end
    check_seq("t1_seq", base, 1, 4);
    chk("t1_sent", words_sent, 4);
    chk("t1_pops", pops, 4);
    enable = 1'b0;
    tick(4);
    chk("t1_idle", idle, 1);

    // 2: consumer stalled; only two pops, head held stable
    load(11, 5);
    base = rx.size();
    pops0 = pops;
    out_ready = 1'b0;
    enable = 1'b1;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      #1;
      chk("t2_hold_data", out_data, 11);
      chk("t2_hold_rd", fifo_rd, 0);
    end
    chk("t2_pops_stall", pops - pops0, 2);
    chk("t2_valid", out_valid, 1);
    out_ready = 1'b1;
    tick(12);
    check_seq("t2_seq", base, 11, 5);
    chk("t2_pops", pops - pops0, 5);
    chk("t2_sent", words_sent, 9);
    enable = 1'b0;
    tick(4);

    // 3: fifo_empty forced high on alternate cycles
    load(21, 4);
    base = rx.size();
    pops0 = pops;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      empty_force = (i % 2 == 0);
      #1;
      if (empty_force) chk("t3_no_pop_empty", fifo_rd, 0);
    end
    empty_force = 1'b0;
    tick(4);
    check_seq("t3_seq", base, 21, 4);
    chk("t3_pops", pops - pops0, 4);
    chk("t3_sent", words_sent, 13);
    enable = 1'b0;
    tick(4);

    // 4: enable dropped with one word in the skid and one in flight
    load(31, 5);
    base = rx.size();
    pops0 = pops;
    out_ready = 1'b0;
    enable = 1'b1;
    tick(3);
    enable = 1'b0;
    #1;
    chk("t4_rd_last_run", fifo_rd, 0);
    tick(1);
    out_ready = 1'b1;
    #1;
    chk("t4_drain_not_idle", idle, 0);
    chk("t4_drain_head", out_data, 31);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      #1;
      chk("t4_drain_rd", fifo_rd, 0);
    end
    chk("t4_idle", idle, 1);
    chk("t4_pops", pops - pops0, 2);
    check_seq("t4_seq", base, 31, 2);
    chk("t4_sent", words_sent, 15);

    // 5: 17 handshakes from reset wrap the 4-bit counter to 1
    reset_L = 1'b0;
    tick(2);
    reset_L = 1'b1;
    chk("t5_sent_rst", words_sent, 0);
    load(36, 14);
    base = rx.size();
    enable = 1'b1;
    tick(25);
    check_seq("t5_seq", base, 33, 17);
    chk("t5_sent_wrap", words_sent, 1);
    enable = 1'b0;
    tick(4);

    // 6: reset mid-stream with a full skid
    load(54, 6);
    out_ready = 1'b0;
    enable = 1'b1;
    tick(6);
    chk("t6_full_valid", out_valid, 1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("t6_rst_rd", fifo_rd, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_sent", words_sent, 0);
    chk("t6_rst_idle", idle, 1);
    tick(2);
    reset_L = 1'b1;
    out_ready = 1'b1;
    base = rx.size();
    tick(10);
    check_seq("t6_seq", base, 56, 4);
    chk("t6_sent", words_sent, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
